alu_issue_sequencer: RTL and testbench

- Front-end requester for the RV32I integer ALU. Accepts one OP/OP-IMM instruction word at a time over a valid/ready handshake and decodes it.
- Reads operands from an internal 32x32 register file and drives funct3/operands/enable to the ALU. Holds them for the ALU latency, captures the result and writes it back to rd.
- Sits between instruction fetch and the ALU. Single-issue and in-order, so there are no hazards.

---
 rtl/alu_issue_sequencer_if.sv | 49 ++++
 rtl/alu_issue_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_sequencer_if.sv
// Handshake and ALU bus bundle for the RV32I ALU issue sequencer.
// master: sequencer side; slave: fetch/ALU/retire side.
interface alu_issue_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        alu_enable;
  logic [2:0]  alu_funct3;
  logic        alu_alt;
  logic [31:0] alu_operand_1;
  logic [31:0] alu_operand_2;
  logic [31:0] alu_result;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic        illegal;

  modport master (
    input  instr_valid,
    input  instr,
    input  alu_result,
    output instr_ready,
    output alu_enable,
    output alu_funct3,
    output alu_alt,
    output alu_operand_1,
    output alu_operand_2,
    output retire_valid,
    output retire_rd,
    output retire_data,
    output illegal
  );

  modport slave (
    output instr_valid,
    output instr,
    output alu_result,
    input  instr_ready,
    input  alu_enable,
    input  alu_funct3,
    input  alu_alt,
    input  alu_operand_1,
    input  alu_operand_2,
    input  retire_valid,
    input  retire_rd,
    input  retire_data,
    input  illegal
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Single-issue OP/OP-IMM sequencer: decode, regfile read, ALU issue, writeback.
// Ports: clock, reset_n (async low), bus (instr handshake, ALU drive, retire).
module alu_issue_sequencer #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input logic                   clock,
  input logic                   reset_n,
  alu_issue_sequencer_if.master bus
);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [3:0] WAIT_LAST = 4'(ALU_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ISSUE,
    WAIT,
    WRITEBACK
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic [31:0] r_instr;
  logic        r_ill;
  logic        r_en;
  logic [2:0]  r_f3;
  logic        r_alt;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [3:0]  r_cnt;
  logic        r_rv;
  logic [4:0]  r_rd;
  logic [31:0] r_rdata;
  logic [31:0] r_rf [32];

  logic [6:0]  w_in_opc;
  logic [6:0]  w_in_f7;
  logic [2:0]  w_in_f3;
  logic        w_in_illegal;

  assign w_in_opc = bus.instr[6:0];
  assign w_in_f3  = bus.instr[14:12];
  assign w_in_f7  = bus.instr[31:25];

  // Legality is judged on the incoming word at the accept edge,
  // so the illegal pulse leaves a flop during DECODE.
  always_comb begin
    w_in_illegal = 1'b1;
    unique case (1'b1)
      (w_in_opc == OPC_OP): begin
        w_in_illegal = !((w_in_f7 == 7'h00) ||
                         ((w_in_f7 == 7'h20) &&
                          ((w_in_f3 == 3'd0) || (w_in_f3 == 3'd5))));
      end
      (w_in_opc == OPC_IMM): begin
        unique case (w_in_f3)
          3'd1:    w_in_illegal = (w_in_f7 != 7'h00);
          3'd5:    w_in_illegal = !((w_in_f7 == 7'h00) ||
                                    (w_in_f7 == 7'h20));
          default: w_in_illegal = 1'b0;
        endcase
      end
      default: w_in_illegal = 1'b1;
    endcase
  end

  logic        w_is_op;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm;
  logic [31:0] w_a;
  logic [31:0] w_rs2v;
  logic [31:0] w_b;
  logic        w_shift;
  logic        w_sub;
  logic        w_alt;
  logic        w_slt;
  logic        w_lt;
  logic [31:0] w_op2;

  assign w_is_op = (r_instr[6:0] == OPC_OP);
  assign w_f3    = r_instr[14:12];
  assign w_rd    = r_instr[11:7];
  assign w_rs1   = r_instr[19:15];
  assign w_rs2   = r_instr[24:20];
  assign w_imm   = {{20{r_instr[31]}}, r_instr[31:20]};

  assign w_a    = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
  assign w_rs2v = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];
  assign w_b    = w_is_op ? w_rs2v : w_imm;

  assign w_shift = (w_f3 == 3'd1) || (w_f3 == 3'd5);
  assign w_sub   = w_is_op && r_instr[30] && (w_f3 == 3'd0);
  assign w_alt   = (w_f3 == 3'd5) && r_instr[30];
  assign w_slt   = (w_f3 == 3'd2);
  assign w_lt    = ($signed(w_a) < $signed(w_b));

  // SUB rides the adder: negate rs2 and issue as ADD.
  always_comb begin
    w_op2 = w_b;
    unique case (1'b1)
      w_shift: w_op2 = {27'd0, w_b[4:0]};
      w_sub:   w_op2 = 32'd0 - w_b;
      default: w_op2 = w_b;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_instr <= '0;
      r_ill   <= 1'b0;
      r_en    <= 1'b0;
      r_f3    <= '0;
      r_alt   <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_cnt   <= '0;
      r_rv    <= 1'b0;
      r_rd    <= '0;
      r_rdata <= '0;
    end else begin
      r_ill <= 1'b0;
      r_rv  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.instr_valid && r_ready) begin
            r_instr <= bus.instr;
            r_ill   <= w_in_illegal;
            r_ready <= 1'b0;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if (r_ill) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else if (w_slt) begin
            r_rv    <= 1'b1;
            r_rd    <= w_rd;
            r_rdata <= {31'd0, w_lt};
            r_state <= WRITEBACK;
          end else begin
            r_en    <= 1'b1;
            r_f3    <= w_f3;
            r_alt   <= w_alt;
            r_op1   <= w_a;
            r_op2   <= w_op2;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= WAIT_LAST;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            // Capture while enable is still high.
            r_rdata <= bus.alu_result;
            r_rd    <= w_rd;
            r_rv    <= 1'b1;
            r_en    <= 1'b0;
            r_f3    <= '0;
            r_alt   <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_state <= WRITEBACK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WRITEBACK: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (r_state == WRITEBACK && r_rd != 5'd0) begin
      r_rf[r_rd] <= r_rdata;
    end
  end

  assign bus.instr_ready   = r_ready;
  assign bus.alu_enable    = r_en;
  assign bus.alu_funct3    = r_f3;
  assign bus.alu_alt       = r_alt;
  assign bus.alu_operand_1 = r_op1;
  assign bus.alu_operand_2 = r_op2;
  assign bus.retire_valid  = r_rv;
  assign bus.retire_rd     = r_rd;
  assign bus.retire_data   = r_rdata;
  assign bus.illegal       = r_ill;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer at ALU_LATENCY 1 and 3.
// Directed plan plus random words against an architectural model.
module tb_alu_issue_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  alu_issue_sequencer_if b0 ();
  alu_issue_sequencer_if b1 ();

  alu_issue_sequencer #(.ALU_LATENCY(1)) u_l1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b0.master)
  );

  alu_issue_sequencer #(.ALU_LATENCY(3)) u_l3 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b1.master)
  );

  int          sel = 0;
  logic        d_valid = 1'b0;
  logic [31:0] d_instr = '0;

  assign b0.instr_valid = (sel == 0) && d_valid;
  assign b1.instr_valid = (sel == 1) && d_valid;
  assign b0.instr = d_instr;
  assign b1.instr = d_instr;

  function automatic logic [31:0] alu_f(input logic [2:0] f,
                                        input logic alt,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (f)
      3'd0: return a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // ALU stand-ins: result valid only after LATENCY enabled edges.
  int n0, n1;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) n0 <= 0;
    else n0 <= b0.alu_enable ? n0 + 1 : 0;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) n1 <= 0;
    else n1 <= b1.alu_enable ? n1 + 1 : 0;

  assign b0.alu_result = !b0.alu_enable ? 32'hDEAD_0000 :
    (n0 >= 1) ? alu_f(b0.alu_funct3, b0.alu_alt,
                      b0.alu_operand_1, b0.alu_operand_2)
              : 32'hBAD0_BAD0;
  assign b1.alu_result = !b1.alu_enable ? 32'hDEAD_0001 :
    (n1 >= 3) ? alu_f(b1.alu_funct3, b1.alu_alt,
                      b1.alu_operand_1, b1.alu_operand_2)
              : 32'hBAD1_BAD1;

  logic        o_ready, o_en, o_alt, o_rv, o_ill;
  logic [2:0]  o_f3;
  logic [31:0] o_op1, o_op2, o_rdata;
  logic [4:0]  o_rd;

  always_comb begin
    o_ready = b0.instr_ready;
    o_en    = b0.alu_enable;
    o_alt   = b0.alu_alt;
    o_rv    = b0.retire_valid;
    o_ill   = b0.illegal;
    o_f3    = b0.alu_funct3;
    o_op1   = b0.alu_operand_1;
    o_op2   = b0.alu_operand_2;
    o_rdata = b0.retire_data;
    o_rd    = b0.retire_rd;
    if (sel == 1) begin
      o_ready = b1.instr_ready;
      o_en    = b1.alu_enable;
      o_alt   = b1.alu_alt;
      o_rv    = b1.retire_valid;
      o_ill   = b1.illegal;
      o_f3    = b1.alu_funct3;
      o_op1   = b1.alu_operand_1;
      o_op2   = b1.alu_operand_2;
      o_rdata = b1.retire_data;
      o_rd    = b1.retire_rd;
    end
  end

  logic [31:0] mr [2][32];

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 32; r++) mr[s][r] = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural view of one instruction word.
  task automatic model(input int s, input logic [31:0] w,
                       output logic ill, output logic slt,
                       output logic [4:0] rd, output logic [31:0] val,
                       output logic [2:0] f3, output logic alt,
                       output logic [31:0] op1, output logic [31:0] op2);
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [31:0] a, b;
    logic        is_op, sub;
    opc = w[6:0];
    f7  = w[31:25];
    f3  = w[14:12];
    rd  = w[11:7];
    is_op = (opc == 7'b0110011);
    a = mr[s][w[19:15]];
    b = is_op ? mr[s][w[24:20]] : {{20{w[31]}}, w[31:20]};
    if (is_op)
      ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
    else if (opc == 7'b0010011)
      ill = (f3 == 1) ? (f7 != 0) :
            (f3 == 5) ? !(f7 == 0 || f7 == 7'h20) : 1'b0;
    else
      ill = 1'b1;
    sub = is_op && w[30] && f3 == 0;
    alt = (f3 == 5) && w[30];
    slt = (f3 == 2);
    op1 = a;
    op2 = sub ? 32'd0 - b : b;
    if (f3 == 1 || f3 == 5) op2 = b % 32;
    case (f3)
      3'd0: val = sub ? a - b : a + b;
      3'd1: val = a << b[4:0];
      3'd2: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: val = (a < b) ? 32'd1 : 32'd0;
      3'd4: val = a ^ b;
      3'd5: val = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: val = a | b;
      default: val = a & b;
    endcase
  endtask

  task automatic run(input int s, input logic [31:0] w);
    logic        eill, eslt, ealt;
    logic [4:0]  erd;
    logic [31:0] eval, eop1, eop2;
    logic [2:0]  ef3;
    int          lat, c_ret, c_ill, en_n;
    logic        ops_ok, zero_ok, done;
    logic [4:0]  grd;
    logic [31:0] gdata;
    model(s, w, eill, eslt, erd, eval, ef3, ealt, eop1, eop2);
    lat = (s == 1) ? 3 : 1;
    sel = s;
    @(negedge clock);
    chk("ready_idle", {31'd0, o_ready}, 32'd1);
    d_valid = 1'b1;
    d_instr = w;
    @(posedge clock);
    #1 d_instr = $urandom;
    c_ret = 0; c_ill = 0; en_n = 0;
    ops_ok = 1'b1; zero_ok = 1'b1; done = 1'b0;
    grd = '0; gdata = '0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clock);
      if (c == 2) d_valid = 1'b0;
      if (o_en) begin
        en_n++;
        if (o_f3 !== ef3 || o_alt !== ealt ||
            o_op1 !== eop1 || o_op2 !== eop2) ops_ok = 1'b0;
      end else if (o_f3 !== 3'd0 || o_op1 !== 32'd0 || o_op2 !== 32'd0)
        zero_ok = 1'b0;
      if (o_ill && c_ill == 0) c_ill = c;
      if (o_rv && c_ret == 0) begin
        c_ret = c;
        grd   = o_rd;
        gdata = o_rdata;
      end
      if (c_ill != 0 || c_ret != 0) done = 1'b1;
    end
    @(negedge clock);
    d_valid = 1'b0;
    chk("ready_after", {31'd0, o_ready}, 32'd1);
    chk("pulse_low", {30'd0, o_ill, o_rv}, 32'd0);
    if (eill) begin
      chk("illegal_cycle", c_ill, 1);
      chk("no_retire", c_ret, 0);
    end else begin
      chk("retire_cycle", c_ret, eslt ? 2 : 3 + lat);
      chk("retire_rd", {27'd0, grd}, {27'd0, erd});
      chk("retire_data", gdata, eval);
      chk("illegal_quiet", c_ill, 0);
      if (erd != 0) mr[s][erd] = eval;
    end
    chk("enable_cycles", en_n, (eill || eslt) ? 0 : lat + 1);
    chk("operands", {31'd0, ops_ok}, 32'd1);
    chk("idle_zero", {31'd0, zero_ok}, 32'd1);
  endtask

  function automatic logic [31:0] rnd_instr();
    int unsigned k;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    k   = $urandom_range(0, 9);
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    if (k == 0) return $urandom;
    if (k < 5) begin
      f7 = (k == 1) ? 7'h20 : (k == 2) ? 7'($urandom) : 7'h00;
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
    end
    imm = 12'($urandom);
    if (f3 == 1 || f3 == 5)
      imm[11:5] = (k == 5) ? 7'h20 : (k == 6) ? 7'($urandom) : 7'h00;
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    logic rv_seen;
    clear_model();
    repeat (2) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_outs", {28'd0, o_en, o_alt, o_rv, o_ill}, 32'd0);
      chk("rst_retire", o_rdata | {27'd0, o_rd}, 32'd0);
    end
    sel = 0;
    @(negedge clock);
    reset_n = 1'b1;

    run(0, 32'h00500093);
    run(0, 32'h00108133);
    run(0, 32'h401001B3);
    run(0, 32'h02300213);
    run(0, 32'h004092B3);
    run(0, 32'h4031D513);
    run(0, 32'hFFB00313);
    run(0, 32'h001323B3);
    run(0, 32'h0000006F);
    run(0, 32'h021084B3);
    run(0, 32'h00900013);
    run(0, 32'h00000413);
    for (int i = 0; i < 30; i++) run(0, rnd_instr());

    run(1, 32'h00500093);
    run(1, 32'h401001B3);
    run(1, 32'h4031D513);
    for (int i = 0; i < 30; i++) run(1, rnd_instr());

    run(1, 32'h00500093);
    sel = 1;
    @(negedge clock);
    d_valid = 1'b1;
    d_instr = 32'h00708113;
    @(posedge clock);
    #1 d_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("wait_enable", {31'd0, o_en}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", {28'd0, o_en, o_alt, o_rv, o_ill}, 32'd0);
    chk("rst_mid_ops", o_op1 | o_op2 | {29'd0, o_f3}, 32'd0);
    chk("rst_mid_ready", {31'd0, o_ready}, 32'd1);
    rv_seen = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (o_rv || o_ill) rv_seen = 1'b1;
    end
    chk("rst_no_retire", {31'd0, rv_seen}, 32'd0);
    reset_n = 1'b1;
    clear_model();
    run(1, 32'h00008493);
    run(1, 32'h00500093);
    run(0, 32'h00008493);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
